// File: rtl/ofdm_tx_sample_buffer_pkg.sv
// Shared definitions for the OFDM transmit sample buffer: default sizing,
// FSM state codes and signed saturation limits used by the optional shifter.
package ofdm_tx_sample_buffer_pkg;

  localparam int TXBUF_DATA_SIZE   = 16;
  localparam int TXBUF_ADDR_SIZE   = 9;
  localparam int TXBUF_START_LEVEL = 300;
  localparam int TXBUF_MARGIN      = 8;

  typedef enum logic [1:0] {
    TXBUF_IDLE    = 2'd0,
    TXBUF_PREFILL = 2'd1,
    TXBUF_STREAM  = 2'd2,
    TXBUF_DRAIN   = 2'd3
  } txbuf_state_t;

  // Largest positive two's-complement value of the given width.
  function automatic longint txbuf_sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative two's-complement value of the given width.
  function automatic longint txbuf_sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/ofdm_tx_sample_buffer_sync_fifo.sv
// ofdm_sync_fifo: single-clock FIFO holding packed {I,Q} words.
// The head word is presented continuously; the consumer registers it, so a
// pop is visible downstream one clock after it is requested.
// Push and pop are qualified here so the occupancy never leaves 0..DEPTH;
// a write into a full FIFO is accepted only when a pop frees a slot in the
// same clock.
module ofdm_sync_fifo #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_SIZE:0]   count
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_COUNT = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] ONE_COUNT  = (ADDR_SIZE + 1)'(1);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 push;
  logic                 pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign pop     = rd_en & ~empty;
  assign push    = wr_en & (~full | pop);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofdm_tx_sample_buffer.sv
// ofdm_tx_sample_buffer: elastic I/Q buffer between the OFDM frame generator
// and the DAC. Prefills to START_LEVEL, then replays one sample per DAC
// strobe until the frame is drained. Flags underflow/overflow and end of frame.
// Optional feature macro: OFDM_TXBUF_SHIFT_EN adds a saturating left shift
// (0..3, selected by i_shift at each pop) on the output samples.
module ofdm_tx_sample_buffer
  import ofdm_tx_sample_buffer_pkg::*;
#(
  parameter int DATA_SIZE   = TXBUF_DATA_SIZE,
  parameter int ADDR_SIZE   = TXBUF_ADDR_SIZE,
  parameter int START_LEVEL = TXBUF_START_LEVEL,
  parameter int MARGIN      = TXBUF_MARGIN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  input  logic                 in_valid,
  input  logic                 in_done_transmit,
  output logic                 o_wayt_read_data,
  input  logic                 i_dac_strobe,
  input  logic [1:0]           i_shift,
  output logic [DATA_SIZE-1:0] out_data_i,
  output logic [DATA_SIZE-1:0] out_data_q,
  output logic                 out_valid,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_underflow,
  output logic                 o_overflow,
  output logic [ADDR_SIZE:0]   o_fill
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] START_FILL = (ADDR_SIZE + 1)'(START_LEVEL);
  localparam logic [ADDR_SIZE:0] WAIT_FILL  = (ADDR_SIZE + 1)'(DEPTH - MARGIN);

  txbuf_state_t           state;
  logic                   eof_latch;
  logic                   streaming;
  logic                   fifo_rd_en;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   overflow_now;
  logic [2*DATA_SIZE-1:0] fifo_wr_data;
  logic [2*DATA_SIZE-1:0] fifo_rd_data;
  logic [DATA_SIZE-1:0]   head_i;
  logic [DATA_SIZE-1:0]   head_q;
  logic [DATA_SIZE-1:0]   shaped_i;
  logic [DATA_SIZE-1:0]   shaped_q;

  // The reserve of MARGIN free slots absorbs the generator's pipeline skid
  // after it is told to stop.
  assign o_wayt_read_data = (o_fill < WAIT_FILL);
  assign o_busy           = (state != TXBUF_IDLE);

  assign streaming    = (state == TXBUF_STREAM) || (state == TXBUF_DRAIN);
  assign fifo_rd_en   = i_dac_strobe & streaming;
  assign fifo_pop     = fifo_rd_en & ~fifo_empty;
  assign overflow_now = in_valid & fifo_full & ~fifo_pop;
  assign fifo_wr_data = {in_data_i, in_data_q};
  assign {head_i, head_q} = fifo_rd_data;

  ofdm_sync_fifo #(
    .DATA_SIZE (2 * DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_valid),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_fill)
  );

`ifdef OFDM_TXBUF_SHIFT_EN
  localparam logic signed [DATA_SIZE+2:0] WIDE_MAX = (DATA_SIZE + 3)'(txbuf_sat_max(DATA_SIZE));
  localparam logic signed [DATA_SIZE+2:0] WIDE_MIN = (DATA_SIZE + 3)'(txbuf_sat_min(DATA_SIZE));

  // Shift in a 3-bit-wider signed domain so no magnitude is lost, then clamp.
  function automatic logic [DATA_SIZE-1:0] sat_shift(input logic [DATA_SIZE-1:0] sample,
                                                     input logic [1:0] amount);
    logic signed [DATA_SIZE+2:0] wide;
    wide = $signed({{3{sample[DATA_SIZE-1]}}, sample}) <<< amount;
    if (wide > WIDE_MAX) begin
      return WIDE_MAX[DATA_SIZE-1:0];
    end else if (wide < WIDE_MIN) begin
      return WIDE_MIN[DATA_SIZE-1:0];
    end
    return wide[DATA_SIZE-1:0];
  endfunction

  // Scale the head sample by the shift amount presented alongside the pop.
  always_comb begin
    shaped_i = sat_shift(head_i, i_shift);
    shaped_q = sat_shift(head_q, i_shift);
  end
`else
  logic unused_shift;
  assign unused_shift = ^i_shift;

  // Without the shifter the head sample goes to the DAC untouched.
  always_comb begin
    shaped_i = head_i;
    shaped_q = head_q;
  end
`endif

  // Frame control FSM with registered DAC outputs and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= TXBUF_IDLE;
      eof_latch    <= 1'b0;
      out_data_i   <= '0;
      out_data_q   <= '0;
      out_valid    <= 1'b0;
      o_frame_done <= 1'b0;
      o_underflow  <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      o_frame_done <= 1'b0;
      if (in_done_transmit && (state != TXBUF_IDLE)) begin
        eof_latch <= 1'b1;
      end
      case (state)
        TXBUF_IDLE: begin
          out_data_i <= '0;
          out_data_q <= '0;
          if (in_valid) begin
            state       <= TXBUF_PREFILL;
            eof_latch   <= in_done_transmit;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
          end
        end
        TXBUF_PREFILL: begin
          if (eof_latch) begin
            state <= TXBUF_DRAIN;
          end else if (o_fill >= START_FILL) begin
            state <= TXBUF_STREAM;
          end
        end
        TXBUF_STREAM: begin
          if (i_dac_strobe) begin
            out_valid <= 1'b1;
            if (fifo_empty) begin
              out_data_i  <= '0;
              out_data_q  <= '0;
              o_underflow <= 1'b1;
            end else begin
              out_data_i <= shaped_i;
              out_data_q <= shaped_q;
            end
          end
          if (eof_latch) begin
            state <= TXBUF_DRAIN;
          end
        end
        TXBUF_DRAIN: begin
          if (i_dac_strobe) begin
            if (fifo_empty) begin
              state        <= TXBUF_IDLE;
              eof_latch    <= 1'b0;
              o_frame_done <= 1'b1;
              out_data_i   <= '0;
              out_data_q   <= '0;
            end else begin
              out_valid  <= 1'b1;
              out_data_i <= shaped_i;
              out_data_q <= shaped_q;
            end
          end
        end
        default: state <= TXBUF_IDLE;
      endcase
      if (overflow_now) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule
